// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute bus, extracts load data from the data SRAM,
// and keeps returned load data in a capture buffer across stalls. Optional MEM_WAIT_EN adds variable SRAM latency.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 79,
   parameter int MEM_TO_WB_WD = 70,
   parameter int MEM_TO_RF_WD = 38
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [5:0]              stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
`ifdef MEM_WAIT_EN
   input  logic                    data_sram_rvalid,
`endif
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
   output logic                    stallreq_for_mem
);

   // state  | meaning
   // IDLE   | register holds a non-load or a bubble
   // FIRST  | first cycle of a load, word comes straight from the SRAM
   // HELD   | load held by a stall, word comes from the capture buffer
   // WAIT   | (MEM_WAIT_EN) load still waiting for SRAM rvalid
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FIRST = 2'd1,
      S_HELD  = 2'd2
`ifdef MEM_WAIT_EN
      , S_WAIT = 2'd3
`endif
   } state_t;

   state_t                  state;
   logic [EX_TO_MEM_WD-1:0] stage_bus;
   logic [31:0]             load_buf;
   logic                    buf_valid;
   logic                    rvalid;

`ifdef MEM_WAIT_EN
   assign rvalid = data_sram_rvalid;
`else
   assign rvalid = 1'b1;
`endif

   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[2:0]};

   logic [2:0]  load_op;
   logic [31:0] pc;
   logic        data_ram_en;
   logic [3:0]  data_ram_wen;
   logic        sel_rf_res;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] ex_result;
   logic        is_load;
   logic        in_is_load;

   assign load_op      = stage_bus[78:76];
   assign pc           = stage_bus[75:44];
   assign data_ram_en  = stage_bus[43];
   assign data_ram_wen = stage_bus[42:39];
   assign sel_rf_res   = stage_bus[38];
   assign rf_we        = stage_bus[37];
   assign rf_waddr     = stage_bus[36:32];
   assign ex_result    = stage_bus[31:0];
   assign is_load      = data_ram_en & (data_ram_wen == 4'd0) & sel_rf_res;
   assign in_is_load   = ex_to_mem_bus[43] & (ex_to_mem_bus[42:39] == 4'd0) & ex_to_mem_bus[38];

   logic bubble;
   logic reload;
   assign bubble = stall[3] & ~stall[4];
   assign reload = ~stall[3];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stage_bus <= '0;
         load_buf  <= '0;
         buf_valid <= 1'b0;
         state     <= S_IDLE;
      end else if (bubble) begin
         stage_bus <= '0;
         buf_valid <= 1'b0;
         state     <= S_IDLE;
      end else if (reload) begin
         stage_bus <= ex_to_mem_bus;
         buf_valid <= 1'b0;
         state     <= in_is_load ? S_FIRST : S_IDLE;
      end else begin
         case (state)
            S_FIRST: begin
               if (rvalid) begin
                  load_buf  <= data_sram_rdata;
                  buf_valid <= 1'b1;
                  state     <= S_HELD;
               end
`ifdef MEM_WAIT_EN
               else begin
                  state <= S_WAIT;
               end
`endif
            end
`ifdef MEM_WAIT_EN
            S_WAIT: begin
               if (rvalid) begin
                  load_buf  <= data_sram_rdata;
                  buf_valid <= 1'b1;
                  state     <= S_HELD;
               end
            end
`endif
            default: state <= state;
         endcase
      end
   end

   logic waiting;
`ifdef MEM_WAIT_EN
   assign waiting = ((state == S_FIRST) || (state == S_WAIT)) && !rvalid;
`else
   assign waiting = 1'b0;
`endif
   assign stallreq_for_mem = waiting;

   logic [31:0] raw_word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val;
   logic [31:0] mem_result;
   logic        out_we;

   assign raw_word = ((state == S_HELD) && buf_valid) ? load_buf : data_sram_rdata;

   always_comb begin
      ld_byte = raw_word[7:0];
      case (ex_result[1:0])
         2'd0:    ld_byte = raw_word[7:0];
         2'd1:    ld_byte = raw_word[15:8];
         2'd2:    ld_byte = raw_word[23:16];
         default: ld_byte = raw_word[31:24];
      endcase
      ld_half = ex_result[1] ? raw_word[31:16] : raw_word[15:0];
      case (load_op)
         3'b001:  load_val = {{24{ld_byte[7]}}, ld_byte};
         3'b010:  load_val = {24'd0, ld_byte};
         3'b011:  load_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_val = {16'd0, ld_half};
         default: load_val = raw_word;
      endcase
   end

   assign mem_result    = is_load ? load_val : ex_result;
   assign out_we        = rf_we & ~waiting;
   assign mem_to_wb_bus = {pc, out_we, rf_waddr, mem_result};
   assign mem_to_rf_bus = {out_we, rf_waddr, mem_result};

endmodule
